alu_seq: RTL and testbench

Sequential 8-bit ALU with a single shared 8-bit input bus and a registered 8-bit output bus. A BEGIN pulse starts an operation. Operand A and operand B then arrive on successive cycles, and the result is presented with an END strobe. Intended as a self-contained arithmetic co-processor slice driven by a simple bus master.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_seq_if.sv | 14 +
 rtl/alu_ctrl.sv | 82 ++++++++
 rtl/alu_seq.sv | 129 ++++++++++++
 tb/tb_alu_seq.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential 8-bit ALU.
// Build option ALU_DIV_EN: op_code 2'b11 is DIV when defined, AND otherwise.
package alu_pkg;

    localparam int WIDTH = 8;
    localparam int ITERS = 8;
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_OUT_LO,
        S_OUT_HI
    } state_t;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_SUB = 2'b01;
    localparam op_t OP_MUL = 2'b10;
`ifdef ALU_DIV_EN
    localparam op_t OP_DIV = 2'b11;
`else
    localparam op_t OP_AND = 2'b11;
`endif

    // Datapath enables decoded from the controller state.
    typedef struct packed {
        logic ld_a;
        logic ld_b;
        logic step;
        logic out_lo;
        logic out_hi;
    } ctrl_t;

    // Ops that iterate in EXEC and present a second result in OUT_HI.
    function automatic logic is_multi(op_t op);
`ifdef ALU_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Bus between the master and the sequential ALU: start/op/operand in, result/strobe out.
interface alu_seq_if;
    import alu_pkg::*;

    logic             BEGIN;
    op_t              op_code;
    logic [WIDTH-1:0] inbus;
    logic [WIDTH-1:0] outbus;
    logic             END;

    modport master (output BEGIN, op_code, inbus, input outbus, END);
    modport slave  (input BEGIN, op_code, inbus, output outbus, END);

endinterface

// File: rtl/alu_ctrl.sv
// Sequencing FSM and iteration counter; emits datapath enables and the END strobe.
module alu_ctrl
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  begin_i,
    input  op_t   op_i,
    output op_t   op_o,
    output ctrl_t ctl_o,
    output logic  end_o
);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             end_q, end_d;
    logic             multi;
    logic             last;

    assign multi = is_multi(op_q);
    assign last  = (cnt_q == CNT_W'(ITERS - 1));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        end_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (begin_i) begin
                    op_d    = op_i;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: begin
                cnt_d   = '0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!multi || last) begin
                    state_d = S_OUT_LO;
                    end_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_OUT_LO: state_d = multi ? S_OUT_HI : S_IDLE;
            S_OUT_HI: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
        end
    end

    // The final EXEC cycle both takes the last iteration and loads the primary result.
    always_comb begin
        ctl_o        = '0;
        ctl_o.ld_a   = (state_q == S_LOAD_A);
        ctl_o.ld_b   = (state_q == S_LOAD_B);
        ctl_o.step   = (state_q == S_EXEC) && multi;
        ctl_o.out_lo = (state_q == S_EXEC) && (!multi || last);
        ctl_o.out_hi = (state_q == S_OUT_LO) && multi;
    end

    assign op_o  = op_q;
    assign end_o = end_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential 8-bit ALU: operand/accumulator registers, shared ripple adder, output register.
// Build option ALU_DIV_EN compiles in the restoring divider on op_code 2'b11.
module alu_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    alu_seq_if.slave    bus
);

    op_t   op;
    ctrl_t ctl;
    logic  end_q;

    alu_ctrl u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .begin_i (bus.BEGIN),
        .op_i    (bus.op_code),
        .op_o    (op),
        .ctl_o   (ctl),
        .end_o   (end_q)
    );

    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, out_q, out_d;
    logic [2*WIDTH-1:0] p_q, p_d, p_step;
    logic [WIDTH-1:0]   p_hi, p_lo;
    logic [WIDTH-1:0]   add_x, add_y, sum, primary;
    logic               cin;
    logic [WIDTH:0]     carry;

    assign p_hi = p_q[2*WIDTH-1:WIDTH];
    assign p_lo = p_q[WIDTH-1:0];

    // One adder serves ADD/SUB directly and the accumulate/trial-subtract steps.
    always_comb begin
        add_x = a_q;
        add_y = b_q;
        cin   = 1'b0;
        case (op)
            OP_SUB: begin
                add_y = ~b_q;
                cin   = 1'b1;
            end
            OP_MUL: begin
                add_x = p_hi;
                add_y = a_q;
            end
`ifdef ALU_DIV_EN
            OP_DIV: begin
                add_x = {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
                add_y = ~b_q;
                cin   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign carry[0] = cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_rca
        assign sum[i]       = add_x[i] ^ add_y[i] ^ carry[i];
        assign carry[i + 1] = (add_x[i] & add_y[i]) | (carry[i] & (add_x[i] ^ add_y[i]));
    end

`ifdef ALU_DIV_EN
    // Trial subtract of the 9-bit shifted remainder succeeds if it overflowed 8 bits or no borrow.
    logic no_borrow;
    assign no_borrow = p_hi[WIDTH-1] | carry[WIDTH];
`endif

    always_comb begin
        p_step  = p_q;
        primary = sum;
        case (op)
            OP_MUL: begin
                if (p_lo[0]) p_step = {carry[WIDTH], sum, p_lo[WIDTH-1:1]};
                else         p_step = {1'b0, p_hi, p_lo[WIDTH-1:1]};
                primary = p_step[WIDTH-1:0];
            end
`ifdef ALU_DIV_EN
            OP_DIV: begin
                p_step  = {(no_borrow ? sum : add_x), p_lo[WIDTH-2:0], no_borrow};
                primary = p_step[WIDTH-1:0];
            end
`else
            OP_AND: primary = a_q & b_q;
`endif
            default: ;
        endcase
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        p_d   = p_q;
        out_d = out_q;
        if (ctl.ld_a) a_d = bus.inbus;
        if (ctl.ld_b) begin
            b_d = bus.inbus;
`ifdef ALU_DIV_EN
            p_d = {{WIDTH{1'b0}}, (op == OP_DIV) ? a_q : bus.inbus};
`else
            p_d = {{WIDTH{1'b0}}, bus.inbus};
`endif
        end
        if (ctl.step) p_d = p_step;
        if (ctl.out_lo)      out_d = primary;
        else if (ctl.out_hi) out_d = p_hi;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            out_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            p_q   <= p_d;
            out_q <= out_d;
        end
    end

    assign bus.outbus = out_q;
    assign bus.END    = end_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: expected results queued at drive time, popped at END/OUT_HI.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_seq_if bus ();

    alu_seq u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb_q[$];
    logic [7:0] last_out = 8'h00;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit tb_multi(input logic [1:0] op);
`ifdef ALU_DIV_EN
        return (op == 2'b10) || (op == 2'b11);
`else
        return (op == 2'b10);
`endif
    endfunction

    task automatic push_expected(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0]  r;
        logic [15:0] p;
        case (op)
            2'b00: begin r = a + b; sb_q.push_back(r); end
            2'b01: begin r = a - b; sb_q.push_back(r); end
            2'b10: begin
                p = 16'(a) * 16'(b);
                sb_q.push_back(p[7:0]);
                sb_q.push_back(p[15:8]);
            end
            default: begin
`ifdef ALU_DIV_EN
                if (b == 8'h00) begin
                    sb_q.push_back(8'hFF);
                    sb_q.push_back(a);
                end else begin
                    r = a / b; sb_q.push_back(r);
                    r = a % b; sb_q.push_back(r);
                end
`else
                r = a & b; sb_q.push_back(r);
`endif
            end
        endcase
    endtask

    // Drives one operation; noise=1 raises BEGIN and flips op_code during LOAD_B/EXEC.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input bit noise);
        int         edges;
        bit         got;
        bit         multi;
        logic [7:0] exp;
        multi = tb_multi(op);
        push_expected(op, a, b);
        @(negedge clk); bus.BEGIN = 1'b1; bus.op_code = op; bus.inbus = 8'h5A;
        @(posedge clk); edges = 1;
        @(negedge clk); bus.BEGIN = 1'b0; bus.inbus = a;
        @(posedge clk); edges = 2;
        @(negedge clk); bus.BEGIN = noise; bus.inbus = b;
        if (noise) bus.op_code = ~op;
        @(posedge clk); edges = 3;
        #1 check({tag, "_hold"}, bus.outbus, last_out);
        @(negedge clk); bus.inbus = 8'hC3;
        got = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk); edges++;
            #1;
            if (edges >= 4) bus.BEGIN = 1'b0;
            if (bus.END === 1'b1) got = 1'b1;
        end
        check({tag, "_latency"}, 8'(edges), multi ? 8'd11 : 8'd4);
        if (!got) begin
            sb_q.delete();
            return;
        end
        exp = sb_q.pop_front();
        check({tag, "_lo"}, bus.outbus, exp);
        last_out = exp;
        @(posedge clk); #1;
        check({tag, "_end_pulse"}, {7'b0, bus.END}, 8'h00);
        if (multi) begin
            exp = sb_q.pop_front();
            check({tag, "_hi"}, bus.outbus, exp);
            last_out = exp;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset       = 1'b0;
        bus.BEGIN   = 1'b0;
        bus.op_code = 2'b00;
        bus.inbus   = 8'h00;
        #1;
        check("rst_outbus", bus.outbus, 8'h00);
        check("rst_end", {7'b0, bus.END}, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op("add_3_2",    2'b00, 8'd3,   8'd2,   1'b0);
        run_op("sub_wrap",   2'b01, 8'd2,   8'd3,   1'b0);
        run_op("mul_7_3",    2'b10, 8'd7,   8'd3,   1'b0);
        run_op("mul_ff_ff",  2'b10, 8'hFF,  8'hFF,  1'b0);
`ifdef ALU_DIV_EN
        run_op("div_17_5",   2'b11, 8'd17,  8'd5,   1'b0);
        run_op("div_by_0",   2'b11, 8'd17,  8'd0,   1'b0);
        run_op("div_noise",  2'b11, 8'd200, 8'd7,   1'b1);
`else
        run_op("and_c6_5a",  2'b11, 8'hC6,  8'h5A,  1'b0);
        run_op("and_noise",  2'b11, 8'hF0,  8'h3C,  1'b1);
`endif
        run_op("add_noise",  2'b00, 8'd200, 8'd100, 1'b1);
        run_op("mul_noise",  2'b10, 8'd13,  8'd11,  1'b1);
        run_op("sub_80_01",  2'b01, 8'h80,  8'h01,  1'b0);

        // Abort a MUL mid-EXEC; outbus was non-zero beforehand.
        @(negedge clk); bus.BEGIN = 1'b1; bus.op_code = 2'b10; bus.inbus = 8'h00;
        @(negedge clk); bus.BEGIN = 1'b0; bus.inbus = 8'd9;
        @(negedge clk); bus.inbus = 8'd9;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_end", {7'b0, bus.END}, 8'h00);
        check("midrst_outbus", bus.outbus, 8'h00);
        @(posedge clk); #1;
        check("midrst_hold", bus.outbus, 8'h00);
        @(negedge clk); reset = 1'b1;
        last_out = 8'h00;
        run_op("add_after_rst", 2'b00, 8'd1, 8'd1, 1'b0);

        check("sb_empty", 8'(sb_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
